// File: rtl/robot_cmd_pkg.sv
// Shared drive-command encodings, telemetry status codes and key codes for the IR
// remote path, plus the decoder state type.
package robot_cmd_pkg;

   localparam logic [7:0] CMD_NONE  = 8'h00;
   localparam logic [7:0] CMD_FWD   = 8'h02;
   localparam logic [7:0] CMD_LEFT  = 8'h08;
   localparam logic [7:0] CMD_BRAKE = 8'h10;
   localparam logic [7:0] CMD_RIGHT = 8'h20;
   localparam logic [7:0] CMD_BACK  = 8'h80;

   localparam logic [2:0] STAT_NONE  = 3'b000;
   localparam logic [2:0] STAT_FWD   = 3'b001;
   localparam logic [2:0] STAT_LEFT  = 3'b010;
   localparam logic [2:0] STAT_BRAKE = 3'b011;
   localparam logic [2:0] STAT_RIGHT = 3'b100;
   localparam logic [2:0] STAT_BACK  = 3'b101;

   localparam logic [7:0] KEY_FWD   = 8'h02;
   localparam logic [7:0] KEY_LEFT  = 8'h04;
   localparam logic [7:0] KEY_BRAKE = 8'h05;
   localparam logic [7:0] KEY_RIGHT = 8'h06;
   localparam logic [7:0] KEY_BACK  = 8'h08;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/ir_key_map.sv
// Combinational remote key to {one-hot drive command, telemetry status} lookup.
// Unknown keys map to CMD_NONE / STAT_NONE.
module ir_key_map
   import robot_cmd_pkg::*;
(
   input  logic [7:0] key,
   output logic [7:0] cmd,
   output logic [2:0] motor_stat
);

   always_comb begin
      cmd        = CMD_NONE;
      motor_stat = STAT_NONE;
      case (key)
         KEY_FWD:   begin cmd = CMD_FWD;   motor_stat = STAT_FWD;   end
         KEY_LEFT:  begin cmd = CMD_LEFT;  motor_stat = STAT_LEFT;  end
         KEY_BRAKE: begin cmd = CMD_BRAKE; motor_stat = STAT_BRAKE; end
         KEY_RIGHT: begin cmd = CMD_RIGHT; motor_stat = STAT_RIGHT; end
         KEY_BACK:  begin cmd = CMD_BACK;  motor_stat = STAT_BACK;  end
         default:   begin cmd = CMD_NONE;  motor_stat = STAT_NONE;  end
      endcase
   end

endmodule

// File: rtl/ir_cmd_decoder.sv
// Validates IR remote frames, holds the mapped drive command for HOLD_MS after the
// last accepted press, and counts rejected frames (saturating).
module ir_cmd_decoder
   import robot_cmd_pkg::*;
#(
   parameter int          CLK_HZ     = 50_000_000,
   parameter int          HOLD_MS    = 150,
   parameter int          CHECK_ADDR = 1,
   parameter logic [15:0] EXP_ADDR   = 16'h6B86
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ir_ready,
   input  logic [31:0] ir_data,
   output logic [7:0]  cmd,
   output logic [2:0]  motor_stat,
   output logic        active,
   output logic        cmd_strobe,
   output logic [7:0]  err_cnt
);

   localparam int HOLD_CYC = CLK_HZ / 1000 * HOLD_MS;
   localparam int TW       = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [TW-1:0] TMR_LOAD = TW'(HOLD_CYC - 1);

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [2:0]    stat_q, stat_d;
   logic          strobe_q, strobe_d;
   logic [7:0]    err_q, err_d;
   logic          rdy_q;

   logic       edge_det, frame_ok, addr_ok, key_mapped;
   logic [7:0] map_cmd;
   logic [2:0] map_stat;

   ir_key_map u_key_map (
      .key        (ir_data[23:16]),
      .cmd        (map_cmd),
      .motor_stat (map_stat)
   );

   always_comb begin
      edge_det   = ir_ready & ~rdy_q;
      addr_ok    = (CHECK_ADDR == 0) || (ir_data[15:0] == EXP_ADDR);
      frame_ok   = (ir_data[31:24] == ~ir_data[23:16]) && addr_ok;
      key_mapped = (map_cmd != CMD_NONE);

      state_d = state_q;
      timer_d = timer_q;
      cmd_d   = cmd_q;
      stat_d  = stat_q;
      err_d   = err_q;

      if (edge_det && !frame_ok)
         err_d = sat_inc(err_q);

      case (state_q)
         ST_IDLE: begin
            if (edge_det && frame_ok && key_mapped) begin
               cmd_d   = map_cmd;
               stat_d  = map_stat;
               timer_d = TMR_LOAD;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (timer_q != '0)
               timer_d = timer_q - TW'(1);
            // A valid press beats the timeout; a rejected frame does not.
            if (edge_det && frame_ok && key_mapped) begin
               cmd_d   = map_cmd;
               stat_d  = map_stat;
               timer_d = TMR_LOAD;
            end else if ((edge_det && frame_ok) || (timer_q == '0)) begin
               cmd_d   = CMD_NONE;
               stat_d  = STAT_NONE;
               state_d = ST_IDLE;
            end
         end
         default: begin
            cmd_d   = CMD_NONE;
            stat_d  = STAT_NONE;
            state_d = ST_IDLE;
         end
      endcase

      strobe_d = (cmd_d != cmd_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         timer_q  <= '0;
         cmd_q    <= CMD_NONE;
         stat_q   <= STAT_NONE;
         strobe_q <= 1'b0;
         err_q    <= 8'd0;
         rdy_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         cmd_q    <= cmd_d;
         stat_q   <= stat_d;
         strobe_q <= strobe_d;
         err_q    <= err_d;
         rdy_q    <= ir_ready;
      end
   end

   assign cmd        = cmd_q;
   assign motor_stat = stat_q;
   assign active     = (state_q == ST_HOLD);
   assign cmd_strobe = strobe_q;
   assign err_cnt    = err_q;

endmodule

// File: tb/tb_ir_cmd_decoder.sv
// Bench for ir_cmd_decoder with a 10-cycle hold window: vector table, directed
// corner sequences and randomized frames against a deadline-based reference model.
module tb_ir_cmd_decoder;

   localparam int HOLD_CYC = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ir_ready = 1'b0;
   logic [31:0] ir_data = 32'd0;
   logic [7:0]  cmd;
   logic [2:0]  motor_stat;
   logic        active;
   logic        cmd_strobe;
   logic [7:0]  err_cnt;

   ir_cmd_decoder #(
      .CLK_HZ     (1000),
      .HOLD_MS    (10),
      .CHECK_ADDR (1),
      .EXP_ADDR   (16'h6B86)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ir_ready   (ir_ready),
      .ir_data    (ir_data),
      .cmd        (cmd),
      .motor_stat (motor_stat),
      .active     (active),
      .cmd_strobe (cmd_strobe),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a hold is a deadline in absolute edge count.
   logic [7:0] km_cmd  [256];
   logic [2:0] km_stat [256];
   bit         m_hold;
   logic [7:0] m_cmd;
   logic [2:0] m_stat;
   bit         m_strobe;
   int         m_err;
   bit         m_prev_rdy;
   int         m_cyc;
   int         m_expire;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hold = 0; m_cmd = 8'h00; m_stat = 3'b000; m_strobe = 0;
      m_err = 0; m_prev_rdy = 0; m_cyc = 0; m_expire = 0;
   endtask

   task automatic model_clock(input logic rdy, input logic [31:0] data);
      bit         edg, valid;
      logic [7:0] key, old;
      edg = rdy && !m_prev_rdy;
      m_prev_rdy = rdy;
      m_cyc++;
      key = data[23:16];
      valid = (data[31:24] == ~key) && (data[15:0] == 16'h6B86);
      old = m_cmd;
      if (edg && !valid && m_err < 255) m_err++;
      if (edg && valid && km_cmd[key] != 8'h00) begin
         m_cmd = km_cmd[key]; m_stat = km_stat[key];
         m_hold = 1; m_expire = m_cyc + HOLD_CYC;
      end else if (m_hold && ((edg && valid) || m_cyc >= m_expire)) begin
         m_hold = 0; m_cmd = 8'h00; m_stat = 3'b000;
      end
      m_strobe = (m_cmd != old);
   endtask

   function automatic logic [31:0] pack_dut();
      return {11'd0, err_cnt, cmd, motor_stat, active, cmd_strobe};
   endfunction

   function automatic logic [31:0] pack_model();
      logic [7:0] e;
      e = 8'(m_err);
      return {11'd0, e, m_cmd, m_stat, m_hold, m_strobe};
   endfunction

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input logic rdy, input logic [31:0] data);
      ir_ready = rdy;
      ir_data  = data;
      @(posedge clk);
      model_clock(rdy, data);
      #1;
      chk("model", pack_dut(), pack_model());
      @(negedge clk);
   endtask

   // Called at a falling edge; leaves rst_n released at a falling edge.
   task automatic do_reset(input logic rdy, input logic [31:0] data);
      rst_n = 1'b0;
      ir_ready = rdy;
      ir_data  = data;
      #1;
      chk("reset_async", pack_dut(), 32'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] frame(input logic [7:0] k);
      return {~k, k, 16'h6B86};
   endfunction

   function automatic logic [31:0] rand_frame();
      logic [7:0] keys [5];
      logic [7:0] k;
      keys[0] = 8'h02; keys[1] = 8'h04; keys[2] = 8'h05; keys[3] = 8'h06; keys[4] = 8'h08;
      k = 8'($urandom);
      case ($urandom_range(0, 5))
         0, 1, 2: return frame(keys[$urandom_range(0, 4)]);
         3:       return frame(k);
         4:       return {~k ^ 8'h10, k, 16'h6B86};
         default: return {~k, k, 16'($urandom)};
      endcase
   endfunction

   typedef struct {
      logic        rdy;
      logic [31:0] data;
      logic [7:0]  cmd;
      logic [2:0]  stat;
      logic        act;
      logic        stb;
      logic [7:0]  err;
   } vec_t;

   vec_t tbl [12];

   initial begin
      int found, stb_cnt, act_cnt;
      logic        r, pr;
      logic [31:0] d;

      for (int i = 0; i < 256; i++) begin km_cmd[i] = 8'h00; km_stat[i] = 3'b000; end
      km_cmd[8'h02] = 8'h02; km_stat[8'h02] = 3'b001;
      km_cmd[8'h04] = 8'h08; km_stat[8'h04] = 3'b010;
      km_cmd[8'h05] = 8'h10; km_stat[8'h05] = 3'b011;
      km_cmd[8'h06] = 8'h20; km_stat[8'h06] = 3'b100;
      km_cmd[8'h08] = 8'h80; km_stat[8'h08] = 3'b101;

      tbl[0]  = '{1'b1, 32'hFD02_6B86, 8'h02, 3'b001, 1'b1, 1'b1, 8'd0};
      tbl[1]  = '{1'b0, 32'hFD02_6B86, 8'h02, 3'b001, 1'b1, 1'b0, 8'd0};
      tbl[2]  = '{1'b1, 32'hF906_6B86, 8'h20, 3'b100, 1'b1, 1'b1, 8'd0};
      tbl[3]  = '{1'b0, 32'hF906_6B86, 8'h20, 3'b100, 1'b1, 1'b0, 8'd0};
      tbl[4]  = '{1'b1, 32'hFF02_6B86, 8'h20, 3'b100, 1'b1, 1'b0, 8'd1};
      tbl[5]  = '{1'b0, 32'hFF02_6B86, 8'h20, 3'b100, 1'b1, 1'b0, 8'd1};
      tbl[6]  = '{1'b1, 32'hFD02_1234, 8'h20, 3'b100, 1'b1, 1'b0, 8'd2};
      tbl[7]  = '{1'b0, 32'hFD02_1234, 8'h20, 3'b100, 1'b1, 1'b0, 8'd2};
      tbl[8]  = '{1'b1, 32'hF609_6B86, 8'h00, 3'b000, 1'b0, 1'b1, 8'd2};
      tbl[9]  = '{1'b0, 32'hF609_6B86, 8'h00, 3'b000, 1'b0, 1'b0, 8'd2};
      tbl[10] = '{1'b1, 32'hF609_6B86, 8'h00, 3'b000, 1'b0, 1'b0, 8'd2};
      tbl[11] = '{1'b0, 32'hF609_6B86, 8'h00, 3'b000, 1'b0, 1'b0, 8'd2};

      // Power-on reset
      model_reset();
      @(negedge clk);
      do_reset(1'b0, 32'd0);
      step(1'b0, 32'd0);
      chk("reset_state", pack_dut(), 32'd0);

      // Hold with reloads every 8 cycles, then silence until timeout
      stb_cnt = 0;
      for (int rep = 0; rep < 4; rep++) begin
         step(1'b1, 32'hFD02_6B86);
         if (cmd_strobe) stb_cnt++;
         if (rep < 3) for (int j = 0; j < 7; j++) begin
            step(1'b0, 32'hFD02_6B86);
            if (cmd_strobe) stb_cnt++;
         end
      end
      chk("reload_strobes", 32'(stb_cnt), 32'd1);
      chk("reload_cmd", {24'd0, cmd}, 32'h02);
      found = 0;
      for (int k = 1; k <= 20; k++) begin
         step(1'b0, 32'hFD02_6B86);
         if (found == 0 && cmd == 8'h00) begin
            found = k;
            chk("timeout_outputs", {30'd0, active, cmd_strobe}, 32'b01);
         end
      end
      chk("timeout_cycles", 32'(found), 32'(HOLD_CYC));

      // Valid edge on the timer==0 cycle keeps the hold
      step(1'b1, 32'hFD02_6B86);
      for (int j = 0; j < HOLD_CYC - 1; j++) step(1'b0, 32'hFD02_6B86);
      step(1'b1, 32'hF906_6B86);
      chk("edge_at_timeout", {23'd0, active, cmd, cmd_strobe}, {23'd0, 1'b1, 8'h20, 1'b1});
      // Rejected frame on the timer==0 cycle lets the timeout fire
      for (int j = 0; j < HOLD_CYC - 1; j++) step(1'b0, 32'hF906_6B86);
      step(1'b1, 32'hFF02_6B86);
      chk("bad_at_timeout", {23'd0, active, cmd, cmd_strobe}, {23'd0, 1'b0, 8'h00, 1'b1});
      step(1'b0, 32'hFF02_6B86);

      // Reset mid-hold, ir_ready already high at release, then held high 50 cycles
      step(1'b1, 32'hFD02_6B86);
      for (int j = 0; j < 3; j++) step(1'b0, 32'hFD02_6B86);
      do_reset(1'b1, 32'hF708_6B86);
      act_cnt = 0;
      for (int j = 0; j < 50; j++) begin
         step(1'b1, 32'hF708_6B86);
         if (j == 0) chk("edge_after_reset", {24'd0, cmd}, 32'h80);
         if (active) act_cnt++;
      end
      chk("held_high_one_event", 32'(act_cnt), 32'(HOLD_CYC));
      step(1'b0, 32'hF708_6B86);

      // Vector table: accept, change, checksum/address reject, stop, unmapped in IDLE
      do_reset(1'b0, 32'd0);
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].rdy, tbl[i].data);
         chk($sformatf("vec%0d", i), pack_dut(),
             {11'd0, tbl[i].err, tbl[i].cmd, tbl[i].stat, tbl[i].act, tbl[i].stb});
      end

      // Randomized traffic; data only changes while ir_ready is low
      pr = 1'b0;
      d  = 32'd0;
      for (int i = 0; i < 2000; i++) begin
         r = ($urandom_range(0, 5) == 0);
         if (!(r && pr)) d = rand_frame();
         step(r, d);
         pr = r;
      end

      // Error counter saturation
      do_reset(1'b0, 32'd0);
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 32'hFF02_6B86);
         step(1'b0, 32'hFF02_6B86);
      end
      chk("err_saturate", {24'd0, err_cnt}, 32'd255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
